// File: rtl/mac_pin_driver.sv
// mac_pin_driver: host-side sequencer for the mac load/compute pins.
// Serialises one operand frame, fires a compute and captures the result.
module mac_pin_driver #(
    parameter int RESULT_LAT = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        op_valid,
    output logic        op_ready,
    input  logic [31:0] op_data,
    input  logic        op_clr,
    output logic        res_valid,
    input  logic        res_ready,
    output logic [15:0] res_data,
    output logic        busy,
    output logic [7:0]  mac_in,
    output logic        mac_ld1,
    output logic        mac_ld2,
    output logic        mac_ld3,
    output logic        mac_ld4,
    output logic        mac_ld,
    output logic        mac_clken,
    output logic        mac_rst,
    input  logic [15:0] mac_out
);

    typedef enum logic [3:0] {
        IDLE,
        CLR,
        L1,
        L2,
        L3,
        L4,
        FIRE,
        WAIT,
        HOLD
    } state_t;

    localparam logic [3:0] WAIT_INIT = 4'(RESULT_LAT - 1);

    state_t      state;
    state_t      state_nx;
    logic [31:0] frame;
    logic [3:0]  cnt;
    logic        load;
    logic        capture;

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            frame    <= '0;
            cnt      <= '0;
            res_data <= '0;
        end else begin
            state <= state_nx;
            if (load) begin
                frame <= op_data;
            end
            if (state == FIRE) begin
                cnt <= WAIT_INIT;
            end else if (state == WAIT && cnt != 4'd0) begin
                cnt <= cnt - 4'd1;
            end
            if (capture) begin
                res_data <= mac_out;
            end
        end
    end

    // The frame's clear request is carried by the CLR/L1 choice itself.
    always_comb begin
        state_nx  = state;
        load      = 1'b0;
        capture   = 1'b0;
        op_ready  = 1'b0;
        res_valid = 1'b0;
        mac_in    = '0;
        mac_ld1   = 1'b0;
        mac_ld2   = 1'b0;
        mac_ld3   = 1'b0;
        mac_ld4   = 1'b0;
        mac_ld    = 1'b0;
        mac_clken = 1'b0;
        mac_rst   = 1'b0;
        unique case (state)
            IDLE: begin
                op_ready = !rst;
                if (op_valid) begin
                    load     = 1'b1;
                    state_nx = op_clr ? CLR : L1;
                end
            end
            CLR: begin
                mac_rst   = 1'b1;
                mac_clken = 1'b1;
                state_nx  = L1;
            end
            L1: begin
                mac_in    = frame[7:0];
                mac_ld1   = 1'b1;
                mac_clken = 1'b1;
                state_nx  = L2;
            end
            L2: begin
                mac_in    = frame[15:8];
                mac_ld2   = 1'b1;
                mac_clken = 1'b1;
                state_nx  = L3;
            end
            L3: begin
                mac_in    = frame[23:16];
                mac_ld3   = 1'b1;
                mac_clken = 1'b1;
                state_nx  = L4;
            end
            L4: begin
                mac_in    = frame[31:24];
                mac_ld4   = 1'b1;
                mac_clken = 1'b1;
                state_nx  = FIRE;
            end
            FIRE: begin
                mac_ld    = 1'b1;
                mac_clken = 1'b1;
                state_nx  = WAIT;
            end
            WAIT: begin
                mac_clken = 1'b1;
                if (cnt == 4'd0) begin
                    capture  = 1'b1;
                    state_nx = HOLD;
                end
            end
            HOLD: begin
                res_valid = 1'b1;
                if (res_ready) begin
                    state_nx = IDLE;
                end
            end
            default: begin
                state_nx = IDLE;
            end
        endcase
    end

    assign busy = (state != IDLE);

endmodule

// File: tb/tb_mac_pin_driver.sv
// Bench for mac_pin_driver: two instances (latency 2 and 15), a pin-level
// mac model each, and a per-cycle schedule model derived from frame timing.
module tb_mac_pin_driver;

    logic        clk = 1'b0;
    logic        rst;
    logic        op_valid  [2];
    logic        op_ready  [2];
    logic [31:0] op_data   [2];
    logic        op_clr    [2];
    logic        res_valid [2];
    logic        res_ready [2];
    logic [15:0] res_data  [2];
    logic        busy      [2];
    logic [7:0]  mac_in    [2];
    logic        mac_ld1   [2];
    logic        mac_ld2   [2];
    logic        mac_ld3   [2];
    logic        mac_ld4   [2];
    logic        mac_ld    [2];
    logic        mac_clken [2];
    logic        mac_rst   [2];
    logic [15:0] mac_out   [2];

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    bit mon_en = 1'b0;

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [63:0] got,
                         input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)",
                     tag, got, exp, cyc);
        end
    endtask

    function automatic logic [17:0] pins(input int i);
        return {op_ready[i], res_valid[i], busy[i],
                mac_ld4[i], mac_ld3[i], mac_ld2[i], mac_ld1[i],
                mac_ld[i], mac_clken[i], mac_rst[i], mac_in[i]};
    endfunction

    function automatic logic [15:0] prod(input logic [31:0] d);
        int p;
        p = int'(d[7:0]) * int'(d[15:8]) + int'(d[23:16]) * int'(d[31:24]);
        return 16'(p);
    endfunction

    for (genvar g = 0; g < 2; g++) begin : inst
        localparam int LAT = (g == 0) ? 2 : 15;

        mac_pin_driver #(.RESULT_LAT(LAT)) u_dut (
            .clk       (clk),
            .rst       (rst),
            .op_valid  (op_valid[g]),
            .op_ready  (op_ready[g]),
            .op_data   (op_data[g]),
            .op_clr    (op_clr[g]),
            .res_valid (res_valid[g]),
            .res_ready (res_ready[g]),
            .res_data  (res_data[g]),
            .busy      (busy[g]),
            .mac_in    (mac_in[g]),
            .mac_ld1   (mac_ld1[g]),
            .mac_ld2   (mac_ld2[g]),
            .mac_ld3   (mac_ld3[g]),
            .mac_ld4   (mac_ld4[g]),
            .mac_ld    (mac_ld[g]),
            .mac_clken (mac_clken[g]),
            .mac_rst   (mac_rst[g]),
            .mac_out   (mac_out[g])
        );

        // mac stand-in: output is only correct on the single capture cycle
        logic [7:0]  ra, rb, rc, rd;
        logic [15:0] racc;
        int          mcnt = 0;

        always @(posedge clk) begin
            if (mac_clken[g] === 1'b1) begin
                if (mac_rst[g]) begin
                    ra <= '0; rb <= '0; rc <= '0; rd <= '0;
                    racc <= '0;
                end else begin
                    if (mac_ld1[g]) ra <= mac_in[g];
                    if (mac_ld2[g]) rb <= mac_in[g];
                    if (mac_ld3[g]) rc <= mac_in[g];
                    if (mac_ld4[g]) rd <= mac_in[g];
                    if (mac_ld[g])
                        racc <= 16'(ra) * 16'(rb) + 16'(rc) * 16'(rd);
                end
            end
        end

        always @(posedge clk) begin
            if (mac_clken[g] === 1'b1 && mac_ld[g] === 1'b1) mcnt <= LAT;
            else if (mcnt > 0) mcnt <= mcnt - 1;
        end

        assign mac_out[g] = (mcnt == 1) ? racc : ~racc;

        // k: cycles since the accept edge, -1 when idle
        int          k = -1;
        bit          mclr = 1'b0;
        logic [31:0] mdata = '0;
        logic [15:0] exp_res = '0;

        function automatic logic [17:0] exp_pins(input int kk, input bit cc,
                                                 input logic [31:0] dd,
                                                 input logic rr);
            logic [3:0] lds;
            logic       ordy, rv, bsy, ldx, ce, mr;
            logic [7:0] mi;
            int         off;
            lds = '0; ordy = 0; rv = 0; bsy = 0; ldx = 0; ce = 0; mr = 0;
            mi = '0;
            off = kk - int'(cc);
            if (kk < 0) begin
                ordy = !rr;
            end else begin
                bsy = 1'b1;
                if (cc && kk == 1) begin
                    mr = 1'b1; ce = 1'b1;
                end else if (off <= 4) begin
                    ce = 1'b1;
                    lds[off-1] = 1'b1;
                    mi = dd[8*(off-1) +: 8];
                end else if (off == 5) begin
                    ldx = 1'b1; ce = 1'b1;
                end else if (off <= 5 + LAT) begin
                    ce = 1'b1;
                end else begin
                    rv = 1'b1;
                end
            end
            return {ordy, rv, bsy, lds, ldx, ce, mr, mi};
        endfunction

        always @(negedge clk) begin : mon
            int off;
            if (mon_en) begin
                check($sformatf("pins%0d", g), pins(g),
                      exp_pins(k, mclr, mdata, rst));
                check($sformatf("res_data%0d", g), res_data[g], exp_res);
            end
            off = k - int'(mclr);
            if (rst) begin
                k = -1;
                exp_res = '0;
            end else if (k < 0) begin
                if (op_valid[g]) begin
                    k = 1;
                    mclr = op_clr[g];
                    mdata = op_data[g];
                end
            end else begin
                if (off == 5 + LAT) exp_res = prod(mdata);
                if (off >= 6 + LAT && res_ready[g]) k = -1;
                else k++;
            end
        end
    end

    task automatic send(input int i, input logic [31:0] d, input logic c,
                        output int t0);
        int n = 0;
        op_valid[i] = 1'b1;
        op_data[i] = d;
        op_clr[i] = c;
        forever begin
            @(negedge clk);
            if (op_ready[i]) break;
            n++;
            if (n > 200) begin
                check("send_timeout", 0, 1);
                break;
            end
        end
        @(posedge clk);
        t0 = cyc;
        #1;
        op_valid[i] = 1'b0;
        op_data[i] = $urandom;
        op_clr[i] = 1'($urandom);
    endtask

    task automatic wait_res(input int i, input int t0, input int exp_c,
                            input logic [15:0] exp_d);
        for (int n = 0; n < 80; n++) begin
            @(negedge clk);
            if (res_valid[i]) begin
                check("res_cycle", cyc - t0, exp_c);
                check("res_value", res_data[i], exp_d);
                return;
            end
        end
        check("res_timeout", 0, 1);
    endtask

    task automatic retire(input int i);
        @(posedge clk);
        #1;
        res_ready[i] = 1'b1;
        @(posedge clk);
        #1;
        res_ready[i] = 1'b0;
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int          t0;
        int          tr;
        int          acc [$];
        int          first_rv;
        bit          sim;
        bit          seen;
        logic [31:0] d;
        logic        c;
        logic [15:0] hold_v;
        logic [7:0]  t2_in [4];

        t2_in = '{8'd3, 8'd5, 8'd7, 8'd11};
        rst = 1'b1;
        for (int i = 0; i < 2; i++) begin
            op_valid[i] = 1'($urandom);
            op_data[i] = $urandom;
            op_clr[i] = 1'($urandom);
            res_ready[i] = 1'($urandom);
        end
        @(posedge clk);
        #1;

        // reset with random inputs
        for (int n = 0; n < 3; n++) begin
            for (int i = 0; i < 2; i++) begin
                op_valid[i] = 1'($urandom);
                op_data[i] = $urandom;
                op_clr[i] = 1'($urandom);
                res_ready[i] = 1'($urandom);
            end
            @(negedge clk);
            for (int i = 0; i < 2; i++) begin
                check("rst_pins", pins(i), 18'd0);
                check("rst_res", res_data[i], 16'd0);
            end
            @(posedge clk);
            #1;
        end
        for (int i = 0; i < 2; i++) begin
            op_valid[i] = 1'b0;
            op_data[i] = '0;
            op_clr[i] = 1'b0;
            res_ready[i] = 1'b0;
        end
        rst = 1'b0;
        mon_en = 1'b1;
        @(negedge clk);
        check("rst_release_ready", op_ready[0], 1'b1);
        @(posedge clk);
        #1;

        // single directed frame
        send(0, 32'h0B07_0503, 1'b0, t0);
        for (int n = 1; n <= 5; n++) begin
            @(negedge clk);
            check("t2_cycle", cyc - t0, n);
            check("t2_in", mac_in[0], (n <= 4) ? t2_in[n-1] : 8'd0);
            check("t2_strobes",
                  {mac_ld[0], mac_ld4[0], mac_ld3[0], mac_ld2[0], mac_ld1[0]},
                  5'b00001 << (n - 1));
        end
        wait_res(0, t0, 8, 16'h005C);

        // backpressure
        hold_v = res_data[0];
        for (int n = 0; n < 10; n++) begin
            @(negedge clk);
            check("bp_data", res_data[0], hold_v);
            check("bp_pins", {res_valid[0], op_ready[0], mac_clken[0]},
                  3'b100);
        end
        retire(0);
        @(negedge clk);
        check("bp_idle", {busy[0], op_ready[0]}, 2'b01);
        @(posedge clk);
        #1;

        // clear
        d = $urandom;
        send(0, d, 1'b1, t0);
        @(negedge clk);
        check("clr_c1", {mac_rst[0], mac_ld1[0]}, 2'b10);
        @(negedge clk);
        check("clr_c2", {mac_rst[0], mac_ld1[0]}, 2'b01);
        wait_res(0, t0, 9, prod(d));
        retire(0);

        // abort during L3
        send(0, $urandom, 1'b0, t0);
        @(posedge clk);
        @(posedge clk);
        #1;
        check("ab_l3", mac_ld3[0], 1'b1);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        check("ab_pins", {mac_ld1[0], mac_ld2[0], mac_ld3[0], mac_ld4[0],
                          mac_ld[0], mac_rst[0], mac_clken[0], res_valid[0],
                          busy[0]}, 9'd0);
        seen = 1'b0;
        for (int n = 0; n < 30; n++) begin
            @(negedge clk);
            if (res_valid[0]) seen = 1'b1;
        end
        check("ab_no_result", seen, 1'b0);
        @(posedge clk);
        #1;
        d = $urandom;
        send(0, d, 1'b0, t0);
        wait_res(0, t0, 8, prod(d));
        retire(0);

        // randomized frames, some retired together with the next offer
        d = $urandom;
        c = 1'($urandom);
        sim = 1'b0;
        tr = 0;
        for (int n = 0; n < 24; n++) begin
            send(0, d, c, t0);
            if (sim) check("simul_accept", t0 - tr, 1);
            wait_res(0, t0, 8 + int'(c), prod(d));
            repeat ($urandom_range(0, 3)) @(negedge clk);
            d = $urandom;
            c = 1'($urandom);
            sim = 1'($urandom);
            @(posedge clk);
            #1;
            res_ready[0] = 1'b1;
            if (sim) begin
                op_valid[0] = 1'b1;
                op_data[0] = d;
                op_clr[0] = c;
            end
            @(posedge clk);
            tr = cyc;
            #1;
            res_ready[0] = 1'b0;
        end

        // extremes, RESULT_LAT=15, back-to-back
        res_ready[1] = 1'b1;
        op_data[1] = 32'hFFFF_FFFF;
        op_clr[1] = 1'b0;
        op_valid[1] = 1'b1;
        first_rv = -1;
        for (int n = 0; n < 120 && acc.size() < 4; n++) begin
            @(negedge clk);
            if (acc.size() > 0 && first_rv < 0 && res_valid[1]) begin
                first_rv = cyc - acc[0];
                check("x_res_value", res_data[1], 16'hFC02);
            end
            if (op_ready[1] && op_valid[1]) acc.push_back(cyc);
        end
        check("x_accepts", acc.size(), 4);
        check("x_res_cycle", first_rv, 21);
        for (int j = 1; j < acc.size(); j++)
            check("x_period", acc[j] - acc[j-1], 22);
        @(posedge clk);
        #1;
        op_valid[1] = 1'b0;
        repeat (30) @(posedge clk);
        #1;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/mac_pin_driver.md
# mac_pin_driver

Host-side sequencer for the `mac` block's pin-level load/compute interface. It accepts one operand frame per valid/ready handshake and serialises the four 8-bit operands onto `mac_in` with the matching `ld1`..`ld4` strobes. It then fires `ld`, waits a fixed compute latency, and captures the 16-bit `mac` result into a valid/ready result port. It is the initiator that drives the `mac` interface, and it replaces bench or host pin-wiggling of that interface.

## Interface
- `RESULT_LAT`, default 2: cycles from the `mac_ld` pulse until `mac_out` is stable. Legal range 1..15.

- `clk`  in  1  the single clock; all logic is on its rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `op_valid`  in  1  an operand frame is offered.
- `op_ready`  out  1  the driver accepts a frame; high only in IDLE.
- `op_data`  in  32  operand frame {D[31:24], C[23:16], B[15:8], A[7:0]}.
- `op_clr`  in  1  sampled with the frame; 1 = pulse `mac_rst` before loading.
- `res_valid`  out  1  `res_data` holds a captured result.
- `res_ready`  in  1  the consumer accepts the result.
- `res_data`  out  16  captured `mac_out`.
- `busy`  out  1  high whenever the state is not IDLE.
- `mac_in`  out  8  operand byte to `mac.in`.
- `mac_ld1`, `mac_ld2`, `mac_ld3`, `mac_ld4`  out  1 each  operand load strobes.
- `mac_ld`  out  1  compute strobe.
- `mac_clken`  out  1  `mac` clock enable.
- `mac_rst`  out  1  `mac` clear pulse.
- `mac_out`  in  16  `mac` result.

## Operation
- **States:** IDLE, CLR, L1, L2, L3, L4, FIRE, WAIT, HOLD.
- **IDLE**
  - `op_ready`=1.
  - When `op_valid`=1, the frame and `op_clr` are registered.
  - Next state is CLR if `op_clr`=1, otherwise L1.
- **CLR**
  - `mac_rst`=1 and `mac_clken`=1 for one cycle, then L1.
- **L1..L4**
  - Ln drives `mac_in` = the n-th operand byte (L1=A, L2=B, L3=C, L4=D) and `mac_ldn`=1 for one cycle.
- **FIRE**
  - `mac_ld`=1 for one cycle.
  - Loads a down-counter with RESULT_LAT−1, then goes to WAIT.
- **WAIT**
  - Counts down.
  - At count 0, the edge leaving WAIT samples `mac_out` into `res_data` and sets `res_valid`; next state is HOLD.
- **HOLD**
  - `res_valid`=1 and `res_data` is stable.
  - When `res_ready`=1, the next edge clears `res_valid` and returns to IDLE.
- **`mac_clken`:** 1 in CLR, L1..L4, FIRE and WAIT; 0 in IDLE and HOLD.
- **Idle pin values:** `mac_in`=0 in every state except L1..L4. All strobes are 0 outside their own state.
- **Strobe exclusivity:** at most one of `mac_ld1`..`mac_ld4`, `mac_ld` and `mac_rst` is high in any cycle.
- **No frame overlap:**
  - `op_ready`=0 from the accept edge until the cycle after the result handshake.
  - `op_valid` is ignored outside IDLE.
- **`res_data`:** holds the last captured value until the next capture. The driver never modifies or interprets it.

## Timing
- **Reset:** while `rst`=1, every output is 0 at the next edge and the state is IDLE. `op_ready`=1 in the first cycle after `rst` deasserts.
- **Reset mid-operation:** asserting `rst` in any state aborts the frame. Strobes and `res_valid` are 0 after that edge, and no partial result is presented.
- **Cycle numbering:** accept edge = cycle 0. With `op_clr`=0:
  - cycles 1..4: L1..L4;
  - cycle 5: FIRE;
  - cycles 6..5+RESULT_LAT: WAIT;
  - cycle 6+RESULT_LAT: `res_valid` first high.
- **With `op_clr`=1:** every event from L1 onward is shifted one cycle later.
- **Minimum frame period:** 7+RESULT_LAT cycles (result accepted in its first cycle), plus 1 with `op_clr`.
- **Capture point:** `mac_out` is sampled exactly RESULT_LAT edges after the FIRE cycle. Nothing is sampled before or after that edge.
- **Simultaneous `res_ready` and `op_valid`:** the result is retired, and the frame is accepted one cycle later in IDLE.

## Test plan
1. **Reset:** hold `rst` 3 cycles with random inputs → all outputs 0 and `busy`=0; `op_ready`=1 one cycle after release.
2. **Single frame:** A=3, B=5, C=7, D=11, `op_clr`=0, RESULT_LAT=2, behavioural `mac` model computing A·B+C·D → `mac_in` = 3,5,7,11 on cycles 1–4 with only the matching `ld` strobe high; `mac_ld` on cycle 5; `res_valid` on cycle 8 with `res_data`=0x005C.
3. **Backpressure:** hold `res_ready`=0 for 10 cycles after `res_valid` rises → `res_data` is stable, `op_ready`=0 and `mac_clken`=0 throughout; a `res_ready` pulse returns the driver to IDLE on the next cycle.
4. **Clear:** `op_clr`=1 → `mac_rst` is high on cycle 1 only, L1 is on cycle 2, and `res_valid` is on cycle 9.
5. **Abort:** assert `rst` during L3 → all strobes and `mac_clken` are 0 after that edge, no `res_valid` ever appears, and the next frame completes normally.
6. **Extremes and latency:** A=B=C=D=0xFF with RESULT_LAT=15 → `res_valid` on cycle 21 with `res_data`=0xFC02; back-to-back frames are accepted every 22 cycles with `res_ready` tied high.
